// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit common-anode
// seven-segment display.
//
// One anode is driven at a time for REFRESH_DIV clocks. The first BLANK_CYC
// clocks of every slot keep all anodes off so the previous digit's segments
// cannot ghost onto the next one. New data is staged in a pending register by
// 'load' and moved into the displayed register only when digit 7's slot ends,
// so a frame never mixes old and new values.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   data_in     32-bit value, nibble k drives digit k
//   dig_en_in   per-digit enable (1 = shown, 0 = blanked)
//   dp_in       per-digit decimal point (1 = lit)
//   load        single-cycle strobe capturing data_in/dig_en_in/dp_in
//   seg         segments {g,f,e,d,c,b,a}, active-low, registered
//   an          anodes, active-low, one-hot-zero, registered
//   dp          decimal point, active-low, registered
//   frame_done  one-cycle pulse after digit 7's slot ends, registered

module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  dig_en_in,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        dp,
  output logic        frame_done
);

  // Slot counter width; REFRESH_DIV=2 still needs one bit.
  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  // Everything needed to draw one frame.
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dig_en;
    logic [7:0]  dp;
  } frame_t;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  frame_t           disp;
  frame_t           pend;
  logic             pend_valid;

  frame_t           in_word_c;
  logic             slot_end_c;
  logic             boundary_c;
  logic             blank_c;
  logic [3:0]       nib_c;

  // Hex digit to active-low gfedcba pattern.
  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Slot/frame decode and the current digit's drive condition.
  always_comb begin
    in_word_c  = {data_in, dig_en_in, dp_in};
    slot_end_c = (cnt == CNT_W'(REFRESH_DIV - 1));
    boundary_c = slot_end_c && (idx == 3'd7);
    blank_c    = (cnt < CNT_W'(BLANK_CYC)) || !disp.dig_en[idx];
    nib_c      = disp.data[{idx, 2'b00} +: 4];
  end

  // Slot counter and digit index; idx wraps 7->0 on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end_c) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Pending/displayed registers. A load landing on the boundary bypasses
  // pend so the very next frame already shows it and nothing stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else if (boundary_c) begin
      if (load) begin
        disp       <= in_word_c;
        pend       <= in_word_c;
        pend_valid <= 1'b0;
      end else if (pend_valid) begin
        disp       <= pend;
        pend_valid <= 1'b0;
      end
    end else if (load) begin
      pend       <= in_word_c;
      pend_valid <= 1'b1;
    end
  end

  // Registered display drive; every slot opens in the all-off state, so an
  // only moves between digits through 8'hFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary_c;
      if (blank_c) begin
        an  <= 8'hFF;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end else begin
        an  <= ~(8'h01 << idx);
        seg <= enc(nib_c);
        dp  <= ~disp.dp[idx];
      end
    end
  end

endmodule
